button_conditioner: RTL and testbench

//  Front end of the frequency-control path. Takes raw, bouncy, asynchronous push-button

---
 rtl/lockin_ui_pkg.sv | 15 +
 rtl/debounce_channel.sv | 51 +++++
 rtl/button_conditioner.sv | 135 +++++++++++++
 tb/tb_button_conditioner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockin_ui_pkg.sv
// Shared constants and types for the lock-in front-panel user interface.
// Cycle counts assume a 50 MHz system clock.
package lockin_ui_pkg;

    localparam int DEBOUNCE_20MS = 1_000_000;
    localparam int REPEAT_500MS  = 25_000_000;
    localparam int REPEAT_100MS  = 5_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchroniser, stability debounce and a
// one-cycle pulse on the released->pressed transition of the debounced level.
module debounce_channel
    import lockin_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic pressed,
    output logic press_pulse
);

    localparam int   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic          sync_meta;
    logic          sync_out;
    logic          level;
    logic [CW-1:0] count;

    assign level = sync_out ^ ACTIVE_LOW;

    // The level must disagree with the accepted state for DEBOUNCE_CYCLES
    // consecutive samples before it is taken; any agreement restarts the wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta   <= RELEASED;
            sync_out    <= RELEASED;
            count       <= '0;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync_meta   <= key_raw;
            sync_out    <= sync_meta;
            press_pulse <= 1'b0;
            if (level == pressed) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                count       <= '0;
                pressed     <= level;
                press_pulse <= level;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Turns three raw bouncy keys into clean one-cycle pulses, with hold-to-repeat
// on up/down and mutual lock-out while up and down are held together.
module button_conditioner
    import lockin_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEBOUNCE_20MS,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_500MS,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_100MS,
    parameter bit ACTIVE_LOW           = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_up,
    input  logic key_down,
    input  logic key_scale,
    output logic btn_up,
    output logic btn_down,
    output logic btn_scale
);

    localparam int TMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic [1:0]    held;
    logic [1:0]    press;
    logic          scale_pulse;
    logic          scale_held;
    logic          dual;

    repeat_state_t state      [2];
    repeat_state_t state_next [2];
    logic [TW-1:0] timer      [2];
    logic [TW-1:0] timer_next [2];
    logic          pulse_next [2];

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_up (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_up),
        .pressed     (held[0]),
        .press_pulse (press[0])
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_down (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_down),
        .pressed     (held[1]),
        .press_pulse (press[1])
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_scale (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_scale),
        .pressed     (scale_held),
        .press_pulse (scale_pulse)
    );

    assign dual = held[0] & held[1];

    // Entering DELAY from IDLE without a press pulse is how a key left over
    // from a dual press restarts silently: its press edge has already gone.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_next[ch] = state[ch];
            timer_next[ch] = timer[ch];
            pulse_next[ch] = 1'b0;
            if (!held[ch] || dual) begin
                state_next[ch] = IDLE;
                timer_next[ch] = '0;
            end else begin
                unique case (state[ch])
                    IDLE: begin
                        state_next[ch] = DELAY;
                        timer_next[ch] = '0;
                        pulse_next[ch] = press[ch];
                    end
                    DELAY: begin
                        if (timer[ch] == TW'(REPEAT_DELAY_CYCLES - 1)) begin
                            state_next[ch] = REPEAT;
                            timer_next[ch] = '0;
                            pulse_next[ch] = 1'b1;
                        end else begin
                            timer_next[ch] = timer[ch] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (timer[ch] == TW'(REPEAT_PERIOD_CYCLES - 1)) begin
                            timer_next[ch] = '0;
                            pulse_next[ch] = 1'b1;
                        end else begin
                            timer_next[ch] = timer[ch] + 1'b1;
                        end
                    end
                    default: begin
                        state_next[ch] = IDLE;
                        timer_next[ch] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= IDLE;
                timer[ch] <= '0;
            end
            btn_up    <= 1'b0;
            btn_down  <= 1'b0;
            btn_scale <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= state_next[ch];
                timer[ch] <= timer_next[ch];
            end
            btn_up    <= pulse_next[0];
            btn_down  <= pulse_next[1];
            btn_scale <= scale_pulse;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with fixed pulse timings,
// then random key activity checked cycle by cycle against a behavioural model.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic reset;
    logic key_up;
    logic key_down;
    logic key_scale;
    logic btn_up;
    logic btn_down;
    logic btn_scale;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES      (D),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP),
        .ACTIVE_LOW           (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_scale (key_scale),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_scale (btn_scale)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int t0         = 0;

    logic [127:0] up_mask;
    logic [127:0] down_mask;
    logic [127:0] scale_mask;

    // Behavioural model: a level is accepted once the synchronised key has
    // been steady for D samples; a held key pulses on its press, then 20
    // cycles after it became the only key held, then every 8 cycles.
    logic s1 [3];
    logic s2 [3];
    logic deb [3];
    logic prs [3];
    logic st_val [3];
    int   st_len [3];
    int   start [2];
    logic exp_up    = 1'b0;
    logic exp_down  = 1'b0;
    logic exp_scale = 1'b0;

    always @(posedge clk) begin
        logic raw [3];
        logic e [2];
        logic old;
        int   el;
        cyc++;
        raw[0] = ~key_up;
        raw[1] = ~key_down;
        raw[2] = ~key_scale;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                s1[i]     = 1'b0;
                s2[i]     = 1'b0;
                deb[i]    = 1'b0;
                prs[i]    = 1'b0;
                st_val[i] = 1'b0;
                st_len[i] = 0;
            end
            start[0]  = -1;
            start[1]  = -1;
            exp_up    = 1'b0;
            exp_down  = 1'b0;
            exp_scale = 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!(deb[ch] && !deb[1-ch])) begin
                    start[ch] = -1;
                    e[ch]     = 1'b0;
                end else if (start[ch] < 0) begin
                    start[ch] = cyc;
                    e[ch]     = prs[ch];
                end else begin
                    el    = cyc - start[ch];
                    e[ch] = (el >= RD) && (((el - RD) % RP) == 0);
                end
            end
            exp_up    = e[0];
            exp_down  = e[1];
            exp_scale = prs[2];
            for (int i = 0; i < 3; i++) begin
                old   = s2[i];
                s2[i] = s1[i];
                s1[i] = raw[i];
                if (old == st_val[i]) begin
                    st_len[i]++;
                end else begin
                    st_val[i] = old;
                    st_len[i] = 1;
                end
                prs[i] = 1'b0;
                if (st_len[i] >= D && st_val[i] != deb[i]) begin
                    deb[i] = st_val[i];
                    prs[i] = st_val[i];
                end
            end
        end
    end

    function automatic logic [127:0] bitAt(input int a);
        return 128'(1) << a;
    endfunction

    task automatic checkValue(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkMask(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed pulse map %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int rel;
        checkValue("btn_up", btn_up, exp_up);
        checkValue("btn_down", btn_down, exp_down);
        checkValue("btn_scale", btn_scale, exp_scale);
        rel = cyc - t0;
        if (rel >= 0 && rel < 128) begin
            if (btn_up === 1'b1)    up_mask[rel]    = 1'b1;
            if (btn_down === 1'b1)  down_mask[rel]  = 1'b1;
            if (btn_scale === 1'b1) scale_mask[rel] = 1'b1;
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic runTo(input int rel);
        while (cyc - t0 < rel) stepCycle();
    endtask

    task automatic applyStimulus(input logic up, input logic down, input logic scale);
        key_up    = up;
        key_down  = down;
        key_scale = scale;
    endtask

    task automatic startTest();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        stepCycle();
        stepCycle();
        reset      = 1'b0;
        t0         = cyc;
        up_mask    = '0;
        down_mask  = '0;
        scale_mask = '0;
    endtask

    initial begin
        int hold [3];
        logic lvl [3];

        $display("[TB] idle keys");
        startTest();
        runTo(50);
        checkMask("t1_up", up_mask, '0);
        checkMask("t1_down", down_mask, '0);
        checkMask("t1_scale", scale_mask, '0);

        $display("[TB] bouncing up key");
        startTest();
        runTo(9);
        for (int i = 0; i < 15; i++) begin
            applyStimulus((i % 2) == 0 ? 1'b0 : 1'b1, 1'b1, 1'b1);
            stepCycle();
            stepCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        runTo(60);
        checkMask("t2_up", up_mask, '0);

        $display("[TB] scale press and release");
        startTest();
        runTo(9);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runTo(109);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runTo(125);
        checkMask("t3_scale", scale_mask, bitAt(16));
        checkMask("t3_up", up_mask, '0);

        $display("[TB] down hold-to-repeat");
        startTest();
        runTo(9);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runTo(77);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runTo(100);
        checkMask("t4_down", down_mask, bitAt(16) | bitAt(36) | bitAt(44) | bitAt(52) |
                                        bitAt(60) | bitAt(68) | bitAt(76));
        checkMask("t4_up", up_mask, '0);

        $display("[TB] up and down together");
        startTest();
        runTo(9);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runTo(29);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runTo(49);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runTo(96);
        checkMask("t5_up", up_mask, bitAt(16) | bitAt(76) | bitAt(84) | bitAt(92));
        checkMask("t5_down", down_mask, '0);

        $display("[TB] reset while up held");
        startTest();
        runTo(9);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runTo(39);
        reset = 1'b1;
        runTo(41);
        reset = 1'b0;
        runTo(80);
        checkMask("t6_up", up_mask, bitAt(16) | bitAt(36) | bitAt(48) | bitAt(68) | bitAt(76));

        $display("[TB] random key activity");
        startTest();
        for (int i = 0; i < 3; i++) begin
            hold[i] = 0;
            lvl[i]  = 1'b1;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 60));
                end
                hold[i]--;
            end
            applyStimulus(lvl[0], lvl[1], lvl[2]);
            reset = ($urandom_range(0, 399) == 0);
            stepCycle();
        end
        reset = 1'b0;
        stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
